// File: rtl/sharp_lcd_rx_monitor.sv
// Decodes the LS013B7DH01 serial write stream (SCLK/SI/SCS) into parallel lines with status pulses.
// Latency: line_valid 1 clk after the last data sample edge. There is no backpressure; the serial stream cannot be stalled.
// Optional build macro SHARP_RX_MULTILINE_EN: one SCS window carries several addr+data+trailer groups.
module sharp_lcd_rx_monitor #(
    parameter int LEAD_BITS   = 8,
    parameter int NUM_LINES   = 168,
    parameter int DATA_BITS   = 144,
    parameter int TRAIL_BITS  = 8,
    parameter int SAMPLE_EDGE = 0
) (
    input  logic                 clk_12mhz,
    input  logic                 rst_n,
    input  logic                 SCLK,
    input  logic                 SI,
    input  logic                 SCS,
    output logic                 line_valid,
    output logic [7:0]           line_addr,
    output logic [DATA_BITS-1:0] line_data,
    output logic                 mode_vcom,
    output logic                 clear_pulse,
    output logic                 frame_err,
    output logic                 addr_err,
    output logic                 busy
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEAD   = 3'd1;
    localparam logic [2:0] S_MODE   = 3'd2;
    localparam logic [2:0] S_ADDR   = 3'd3;
    localparam logic [2:0] S_DATA   = 3'd4;
    localparam logic [2:0] S_TRAIL  = 3'd5;
    localparam logic [2:0] S_IGNORE = 3'd6;

`ifdef SHARP_RX_MULTILINE_EN
    localparam bit MULTILINE = 1'b1;
`else
    localparam bit MULTILINE = 1'b0;
`endif

    localparam logic [2:0] S_AFTER_TRAIL = MULTILINE ? S_ADDR : S_IGNORE;

    localparam int MAX_AB = (DATA_BITS > LEAD_BITS) ? DATA_BITS : LEAD_BITS;
    localparam int MAX_CT = (MAX_AB > TRAIL_BITS) ? MAX_AB : TRAIL_BITS;
    localparam int MAXF   = (MAX_CT > 8) ? MAX_CT : 8;
    localparam int CW     = $clog2(MAXF + 1);

    logic                 sclk_s1, sclk_s2, sclk_s3;
    logic                 si_s1, si_s2;
    logic                 scs_s1, scs_s2, scs_d;
    logic [2:0]           state;
    logic [CW-1:0]        cnt;
    logic [6:0]           mode_sr;
    logic [7:0]           addr_sr;
    logic [DATA_BITS-2:0] data_sr;

    logic                 samp;
    logic                 scs_rise;
    logic [7:0]           mode_nx;
    logic [7:0]           addr_nx;
    logic [DATA_BITS-1:0] data_nx;

    always_ff @(posedge clk_12mhz or negedge rst_n) begin
        if (!rst_n) begin
            {sclk_s1, sclk_s2, sclk_s3} <= 3'b000;
            {si_s1, si_s2}              <= 2'b00;
            {scs_s1, scs_s2, scs_d}     <= 3'b000;
        end else begin
            sclk_s1 <= SCLK;
            sclk_s2 <= sclk_s1;
            sclk_s3 <= sclk_s2;
            si_s1   <= SI;
            si_s2   <= si_s1;
            scs_s1  <= SCS;
            scs_s2  <= scs_s1;
            scs_d   <= scs_s2;
        end
    end

    assign samp     = (SAMPLE_EDGE != 0) ? (sclk_s2 & ~sclk_s3) : (~sclk_s2 & sclk_s3);
    assign scs_rise = scs_s2 & ~scs_d;
    // Every field is LSB-first, so new bits enter at the top and drift down.
    assign mode_nx  = {si_s2, mode_sr};
    assign addr_nx  = {si_s2, addr_sr[7:1]};
    assign data_nx  = {si_s2, data_sr};
    assign busy     = (state != S_IDLE);

    always_ff @(posedge clk_12mhz or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            mode_sr     <= '0;
            addr_sr     <= '0;
            data_sr     <= '0;
            line_valid  <= 1'b0;
            line_addr   <= '0;
            line_data   <= '0;
            mode_vcom   <= 1'b0;
            clear_pulse <= 1'b0;
            frame_err   <= 1'b0;
            addr_err    <= 1'b0;
        end else begin
            line_valid  <= 1'b0;
            clear_pulse <= 1'b0;
            frame_err   <= 1'b0;
            addr_err    <= 1'b0;
            if (!scs_s2) begin
                // An empty ADDR between groups is the normal end of a multi-line window.
                if (state == S_DATA || (state == S_ADDR && (!MULTILINE || cnt != '0)))
                    frame_err <= 1'b1;
                state <= S_IDLE;
                cnt   <= '0;
            end else if (state == S_IDLE) begin
                if (scs_rise) begin
                    cnt <= '0;
                    if (LEAD_BITS == 0)
                        state <= S_MODE;
                    else if (samp && LEAD_BITS == 1)
                        state <= S_MODE;
                    else begin
                        state <= S_LEAD;
                        cnt   <= samp ? CW'(1) : '0;
                    end
                end
            end else if (samp) begin
                case (state)
                    S_LEAD: begin
                        if (cnt == CW'(LEAD_BITS - 1)) begin
                            cnt   <= '0;
                            state <= S_MODE;
                        end else
                            cnt <= cnt + 1'b1;
                    end
                    S_MODE: begin
                        mode_sr <= mode_nx[7:1];
                        if (cnt == CW'(7)) begin
                            cnt         <= '0;
                            mode_vcom   <= mode_nx[1];
                            clear_pulse <= mode_nx[2];
                            state       <= mode_nx[0] ? S_ADDR : S_IGNORE;
                        end else
                            cnt <= cnt + 1'b1;
                    end
                    S_ADDR: begin
                        addr_sr <= addr_nx;
                        if (cnt == CW'(7)) begin
                            cnt <= '0;
                            if (addr_nx == 8'd0 || addr_nx > 8'(NUM_LINES)) begin
                                addr_err <= 1'b1;
                                state    <= S_IGNORE;
                            end else
                                state <= S_DATA;
                        end else
                            cnt <= cnt + 1'b1;
                    end
                    S_DATA: begin
                        data_sr <= data_nx[DATA_BITS-1:1];
                        if (cnt == CW'(DATA_BITS - 1)) begin
                            cnt        <= '0;
                            line_valid <= 1'b1;
                            line_data  <= data_nx;
                            line_addr  <= addr_sr;
                            state      <= (TRAIL_BITS == 0) ? S_AFTER_TRAIL : S_TRAIL;
                        end else
                            cnt <= cnt + 1'b1;
                    end
                    S_TRAIL: begin
                        if (cnt == CW'(TRAIL_BITS - 1)) begin
                            cnt   <= '0;
                            state <= S_AFTER_TRAIL;
                        end else
                            cnt <= cnt + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sharp_lcd_rx_monitor.sv
// Bench for sharp_lcd_rx_monitor: random serial frames checked against a bit-stream parsing model.
module tb_sharp_lcd_rx_monitor;

    localparam int LEAD = 8;
    localparam int NL   = 168;
    localparam int DB   = 144;
    localparam int TRL  = 8;
`ifdef SHARP_RX_MULTILINE_EN
    localparam bit ML = 1'b1;
`else
    localparam bit ML = 1'b0;
`endif

    logic          clk_12mhz = 1'b0;
    logic          rst_n, SCLK, SI, SCS;
    logic          line_valid, mode_vcom, clear_pulse, frame_err, addr_err, busy;
    logic [7:0]    line_addr;
    logic [DB-1:0] line_data;

    sharp_lcd_rx_monitor dut (
        .clk_12mhz(clk_12mhz), .rst_n(rst_n), .SCLK(SCLK), .SI(SI), .SCS(SCS),
        .line_valid(line_valid), .line_addr(line_addr), .line_data(line_data),
        .mode_vcom(mode_vcom), .clear_pulse(clear_pulse), .frame_err(frame_err),
        .addr_err(addr_err), .busy(busy)
    );

    always #5 clk_12mhz = ~clk_12mhz;

    int            n_checks, n_pass;
    bit            bits[$];
    int            exp_addr[$];
    logic [DB-1:0] exp_data[$];
    int            exp_ferr, exp_aerr, exp_clr;
    logic          exp_vcom;
    int            got_addr[$];
    logic [DB-1:0] got_data[$];
    int            got_ferr, got_aerr, got_clr;

    always @(negedge clk_12mhz) begin
        if (line_valid) begin
            got_addr.push_back(int'(line_addr));
            got_data.push_back(line_data);
        end
        if (frame_err)   got_ferr++;
        if (addr_err)    got_aerr++;
        if (clear_pulse) got_clr++;
    end

    task automatic push_field(input logic [DB-1:0] v, input int n);
        for (int i = 0; i < n; i++) bits.push_back(v[i]);
    endtask

    function automatic logic [DB-1:0] rand_data();
        logic [DB-1:0] d;
        for (int k = 0; k < DB; k++) d[k] = 1'($urandom_range(0, 1));
        return d;
    endfunction

    function automatic logic [DB-1:0] take(input int pos, input int w);
        logic [DB-1:0] v = '0;
        for (int i = 0; i < w; i++) v[i] = bits[pos+i];
        return v;
    endfunction

    // Walks the transmitted bit stream field by field; SCS drops right after the last bit.
    function automatic void model_frame();
        int n, pos;
        logic [7:0] m, a;
        exp_addr.delete(); exp_data.delete();
        exp_ferr = 0; exp_aerr = 0; exp_clr = 0;
        n = bits.size();
        pos = LEAD;
        if (n < pos + 8) return;
        m = take(pos, 8)[7:0];
        exp_vcom = m[1];
        if (m[2]) exp_clr = 1;
        if (!m[0]) return;
        pos += 8;
        while (1) begin
            if (n == pos) begin
                if (!ML) exp_ferr = 1;
                return;
            end
            if (n < pos + 8) begin exp_ferr = 1; return; end
            a = take(pos, 8)[7:0];
            pos += 8;
            if (a == 0 || int'(a) > NL) begin exp_aerr++; return; end
            if (n < pos + DB) begin exp_ferr = 1; return; end
            exp_addr.push_back(int'(a));
            exp_data.push_back(take(pos, DB));
            pos += DB + TRL;
            if (pos > n || !ML) return;
        end
    endfunction

    task automatic clear_obs();
        got_addr.delete(); got_data.delete();
        got_ferr = 0; got_aerr = 0; got_clr = 0;
    endtask

    task automatic scs_up();
        @(negedge clk_12mhz) SCS = 1'b1;
        repeat (6) @(negedge clk_12mhz);
    endtask

    task automatic send_bits();
        foreach (bits[i]) begin
            @(negedge clk_12mhz);
            SI = bits[i];
            SCLK = 1'b1;
            repeat (4) @(negedge clk_12mhz);
            SCLK = 1'b0;
            repeat (4) @(negedge clk_12mhz);
        end
    endtask

    task automatic scs_down();
        repeat (4) @(negedge clk_12mhz);
        SCS = 1'b0;
        repeat (12) @(negedge clk_12mhz);
    endtask

    task automatic do_frame();
        clear_obs();
        scs_up();
        send_bits();
        scs_down();
        model_frame();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk_12mhz);
        n_checks++;
        if ({line_valid, line_addr, line_data, mode_vcom, clear_pulse, frame_err, addr_err, busy} !== '0)
            $display("FAIL reset_outputs got addr=%0h vcom=%0b busy=%0b want all 0", line_addr, mode_vcom, busy);
        else n_pass++;
        rst_n = 1'b1;
        repeat (4) @(negedge clk_12mhz);
        n_checks++;
        if (busy !== 1'b0) $display("FAIL reset_idle_busy got %0b want 0", busy); else n_pass++;
    endtask

    task automatic test_single_line();
        logic [DB-1:0] d = 144'hFFFF_0000_0000_FFFF_0000_FFFF_0000_0000_FFFF;
        bits.delete();
        push_field('0, LEAD); push_field(144'h01, 8); push_field(144'h05, 8);
        push_field(d, DB); push_field('0, 16);
        do_frame();
        n_checks++;
        if (got_addr.size() != 1) $display("FAIL t1_line_count got %0d want 1", got_addr.size()); else n_pass++;
        if (got_addr.size() > 0) begin
            n_checks++;
            if (got_addr[0] !== 5) $display("FAIL t1_addr got %0h want 5", got_addr[0]); else n_pass++;
            n_checks++;
            if (got_data[0] !== d) $display("FAIL t1_data got %h want %h", got_data[0], d); else n_pass++;
        end
        n_checks++;
        if (got_ferr !== 0) $display("FAIL t1_frame_err got %0d want 0", got_ferr); else n_pass++;
        n_checks++;
        if (got_aerr !== exp_aerr) $display("FAIL t1_addr_err got %0d want %0d", got_aerr, exp_aerr); else n_pass++;
        n_checks++;
        if (mode_vcom !== 1'b0) $display("FAIL t1_vcom got %0b want 0", mode_vcom); else n_pass++;
    endtask

    task automatic test_mode_bits();
        bits.delete(); push_field('0, LEAD); push_field(144'h04, 8);
        do_frame();
        n_checks++;
        if (got_clr !== 1) $display("FAIL t2_clear got %0d want 1", got_clr); else n_pass++;
        n_checks++;
        if (got_addr.size() != 0 || mode_vcom !== 1'b0)
            $display("FAIL t2_noline_vcom got lines=%0d vcom=%0b want 0/0", got_addr.size(), mode_vcom);
        else n_pass++;
        bits.delete(); push_field('0, LEAD); push_field(144'h02, 8);
        do_frame();
        n_checks++;
        if (mode_vcom !== 1'b1) $display("FAIL t2_vcom_set got %0b want 1", mode_vcom); else n_pass++;
        n_checks++;
        if (got_clr !== 0) $display("FAIL t2_no_clear got %0d want 0", got_clr); else n_pass++;
    endtask

    task automatic test_frame_abort();
        logic [DB-1:0] d = rand_data();
        bits.delete(); push_field('0, LEAD); push_field(144'h01, 8); push_field(144'h07, 8);
        push_field(d, 100);
        do_frame();
        n_checks++;
        if (got_ferr !== 1) $display("FAIL t3_frame_err got %0d want 1", got_ferr); else n_pass++;
        n_checks++;
        if (got_addr.size() != 0) $display("FAIL t3_no_line got %0d want 0", got_addr.size()); else n_pass++;
        n_checks++;
        if (line_addr !== 8'h05) $display("FAIL t3_addr_held got %0h want 5", line_addr); else n_pass++;
        bits.delete(); push_field('0, LEAD); push_field(144'h01, 8); push_field(144'h08, 8);
        push_field(d, DB); push_field('0, TRL);
        do_frame();
        n_checks++;
        if (got_addr.size() != 1 || line_addr !== 8'h08 || line_data !== d)
            $display("FAIL t3_recover got lines=%0d addr=%0h want 1 line addr 8", got_addr.size(), line_addr);
        else n_pass++;
        n_checks++;
        if (got_ferr !== 0) $display("FAIL t3_recover_ferr got %0d want 0", got_ferr); else n_pass++;
    endtask

    task automatic test_addr_err();
        int bad[2] = '{0, 169};
        foreach (bad[k]) begin
            bits.delete(); push_field('0, LEAD); push_field(144'h01, 8);
            push_field(144'(bad[k]), 8); push_field(rand_data(), 20);
            clear_obs();
            scs_up();
            send_bits();
            repeat (4) @(negedge clk_12mhz);
            n_checks++;
            if (busy !== 1'b1) $display("FAIL t4_busy_hold[%0d] got %0b want 1", bad[k], busy); else n_pass++;
            scs_down();
            model_frame();
            n_checks++;
            if (busy !== 1'b0) $display("FAIL t4_busy_drop[%0d] got %0b want 0", bad[k], busy); else n_pass++;
            n_checks++;
            if (got_aerr !== 1 || got_aerr !== exp_aerr)
                $display("FAIL t4_addr_err[%0d] got %0d want 1", bad[k], got_aerr);
            else n_pass++;
            n_checks++;
            if (got_addr.size() != 0 || got_ferr != 0)
                $display("FAIL t4_quiet[%0d] got lines=%0d ferr=%0d want 0/0", bad[k], got_addr.size(), got_ferr);
            else n_pass++;
        end
    endtask

    task automatic test_multiline();
        logic [DB-1:0] da = rand_data();
        logic [DB-1:0] db = rand_data();
        bits.delete(); push_field('0, LEAD); push_field(144'h01, 8);
        push_field(144'h01, 8); push_field(da, DB); push_field('0, TRL);
        push_field(144'h02, 8); push_field(db, DB); push_field('0, TRL);
        do_frame();
        n_checks++;
        if (got_addr.size() != (ML ? 2 : 1) || got_addr.size() != exp_addr.size())
            $display("FAIL t5_line_count got %0d want %0d", got_addr.size(), exp_addr.size());
        else n_pass++;
        for (int i = 0; i < exp_addr.size(); i++) if (i < got_addr.size()) begin
            n_checks++;
            if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i])
                $display("FAIL t5_line[%0d] got addr=%0h want %0h", i, got_addr[i], exp_addr[i]);
            else n_pass++;
        end
        n_checks++;
        if (got_ferr !== 0 || got_aerr !== 0)
            $display("FAIL t5_errs got ferr=%0d aerr=%0d want 0/0", got_ferr, got_aerr);
        else n_pass++;
    endtask

    task automatic test_reset_mid_data();
        logic [DB-1:0] d = rand_data();
        bits.delete(); push_field('0, LEAD); push_field(144'h03, 8); push_field(144'h03, 8);
        push_field(d, 50);
        clear_obs();
        scs_up();
        send_bits();
        @(negedge clk_12mhz);
        rst_n = 1'b0;
        SCS = 1'b0;
        repeat (2) @(negedge clk_12mhz);
        n_checks++;
        if ({line_valid, line_addr, line_data, mode_vcom, clear_pulse, frame_err, addr_err, busy} !== '0)
            $display("FAIL t6_reset_outputs got addr=%0h vcom=%0b busy=%0b want all 0", line_addr, mode_vcom, busy);
        else n_pass++;
        rst_n = 1'b1;
        exp_vcom = 1'b0;
        repeat (8) @(negedge clk_12mhz);
        n_checks++;
        if (got_addr.size() != 0 || got_ferr != 0 || busy !== 1'b0)
            $display("FAIL t6_abort_quiet got lines=%0d ferr=%0d busy=%0b want 0", got_addr.size(), got_ferr, busy);
        else n_pass++;
        bits.delete(); push_field('0, LEAD); push_field(144'h01, 8); push_field(144'h2A, 8);
        push_field(d, DB); push_field('0, TRL);
        do_frame();
        n_checks++;
        if (got_addr.size() != 1 || line_addr !== 8'h2A || line_data !== d || mode_vcom !== 1'b0)
            $display("FAIL t6_after_reset got lines=%0d addr=%0h vcom=%0b want 1/2a/0", got_addr.size(), line_addr, mode_vcom);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [7:0] modes[5] = '{8'h01, 8'h03, 8'h05, 8'h07, 8'h02};
        for (int it = 0; it < 6; it++) begin
            int groups = $urandom_range(1, 3);
            bits.delete(); push_field('0, LEAD);
            push_field(144'(modes[$urandom_range(0, 4)]), 8);
            for (int g = 0; g < groups; g++) begin
                int a = ($urandom_range(0, 5) == 0) ? (($urandom_range(0, 1) == 1) ? 0 : $urandom_range(169, 255))
                                                    : $urandom_range(1, NL);
                push_field(144'(a), 8); push_field(rand_data(), DB); push_field(rand_data(), TRL);
            end
            if ($urandom_range(0, 2) == 0) begin
                int cut = $urandom_range(LEAD, bits.size() - 1);
                while (bits.size() > cut) void'(bits.pop_back());
            end
            do_frame();
            n_checks++;
            if (got_addr.size() != exp_addr.size())
                $display("FAIL rnd%0d_lines got %0d want %0d", it, got_addr.size(), exp_addr.size());
            else n_pass++;
            for (int i = 0; i < exp_addr.size(); i++) if (i < got_addr.size()) begin
                n_checks++;
                if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i])
                    $display("FAIL rnd%0d_line%0d got addr=%0h want %0h", it, i, got_addr[i], exp_addr[i]);
                else n_pass++;
            end
            n_checks++;
            if (got_ferr !== exp_ferr || got_aerr !== exp_aerr || got_clr !== exp_clr)
                $display("FAIL rnd%0d_pulses got f/a/c=%0d/%0d/%0d want %0d/%0d/%0d",
                         it, got_ferr, got_aerr, got_clr, exp_ferr, exp_aerr, exp_clr);
            else n_pass++;
            n_checks++;
            if (mode_vcom !== exp_vcom) $display("FAIL rnd%0d_vcom got %0b want %0b", it, mode_vcom, exp_vcom);
            else n_pass++;
        end
    endtask

    initial begin
        rst_n = 1'b0; SCLK = 1'b0; SI = 1'b0; SCS = 1'b0;
        n_checks = 0; n_pass = 0; exp_vcom = 1'b0;
        clear_obs();
        test_reset();
        test_single_line();
        test_mode_bits();
        test_frame_abort();
        test_addr_err();
        test_multiline();
        test_reset_mid_data();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
